// File: rtl/store_align_buffer_if.sv
// store_align_buffer_if: store-commit request, error report and memory write-port bundle
interface store_align_buffer_if #(
  parameter int DEPTH = 4
);
  logic                       st_valid;
  logic [31:0]                st_addr;
  logic [31:0]                st_data;
  logic [2:0]                 st_func;
  logic                       st_ready;
  logic                       err_valid;
  logic [31:0]                err_addr;
  logic                       mem_valid;
  logic [31:0]                mem_addr;
  logic [31:0]                mem_data;
  logic [3:0]                 mem_be;
  logic                       mem_ready;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport master (
    output st_valid, st_addr, st_data, st_func, mem_ready,
    input  st_ready, err_valid, err_addr, mem_valid, mem_addr, mem_data, mem_be, count
  );
  modport slave (
    input  st_valid, st_addr, st_data, st_func, mem_ready,
    output st_ready, err_valid, err_addr, mem_valid, mem_addr, mem_data, mem_be, count
  );
endinterface

// File: rtl/store_align_buffer.sv
// store_align_buffer: lane-aligns committed stores (func 000/100 byte, 001/101 half, 010 word) into an in-order write FIFO; STORE_MERGE_EN merges same-word stores into the youngest non-head entry
module store_align_buffer #(
  parameter int DEPTH = 4
) (
  input logic                 clock,
  input logic                 reset,
  store_align_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_valid_q;
  logic [31:0]   err_addr_q;
  logic [1:0]    off;
  logic          is_b, is_h, is_w, mis, take, enq, deq, merge, empty, full;
  logic [31:0]   al_data;
  logic [3:0]    al_be;
`ifdef STORE_MERGE_EN
  logic [AW-1:0] young;
`endif
  // decode and align the incoming store, derive enqueue/dequeue/merge and next pointers
  always_comb begin
    off      = bus.st_addr[1:0];
    is_b     = bus.st_func[1:0] == 2'b00;
    is_h     = bus.st_func[1:0] == 2'b01;
    is_w     = bus.st_func == 3'b010;
    mis      = !(is_b || (is_h && !off[0]) || (is_w && off == 2'b00));
    al_data  = is_b ? {4{bus.st_data[7:0]}} : is_h ? {2{bus.st_data[15:0]}} : bus.st_data;
    al_be    = is_b ? 4'b0001 << off : is_h ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    empty    = count_q == '0;
    full     = count_q == CW'(DEPTH);
    take     = bus.st_valid && !full;
    deq      = !empty && bus.mem_ready;
`ifdef STORE_MERGE_EN
    young    = wr_ptr_q - AW'(1);
    merge    = take && !mis && count_q > CW'(1) && addr_q[young] == bus.st_addr[31:2];
`else
    merge    = 1'b0;
`endif
    enq      = take && !mis && !merge;
    wr_ptr_d = wr_ptr_q + AW'(enq);
    rd_ptr_d = rd_ptr_q + AW'(deq);
    count_d  = count_q + CW'(enq) - CW'(deq);
  end
  assign bus.st_ready  = !full;
  assign bus.mem_valid = !empty;
  assign bus.mem_addr  = empty ? '0 : {addr_q[rd_ptr_q], 2'b00};
  assign bus.mem_data  = empty ? '0 : data_q[rd_ptr_q];
  assign bus.mem_be    = empty ? '0 : be_q[rd_ptr_q];
  assign bus.err_valid = err_valid_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.count     = count_q;
  // pointers, occupancy and dropped-store report
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_valid_q <= take && mis;
      if (take && mis) err_addr_q <= bus.st_addr;
    end
  end
  // entry storage: allocate at the tail, or fold new lanes into the youngest entry
  always_ff @(posedge clock) begin
    if (enq) begin
      addr_q[wr_ptr_q] <= bus.st_addr[31:2];
      data_q[wr_ptr_q] <= al_data;
      be_q[wr_ptr_q]   <= al_be;
    end
`ifdef STORE_MERGE_EN
    if (merge) begin
      be_q[young] <= be_q[young] | al_be;
      for (int i = 0; i < 4; i++)
        if (al_be[i]) data_q[young][8*i +: 8] <= al_data[8*i +: 8];
    end
`endif
  end
endmodule

// File: tb/tb_store_align_buffer.sv
// tb_store_align_buffer: directed and random stores checked against a queue model of the write buffer
module tb_store_align_buffer;
  localparam int DEPTH = 4;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010, SBU = 3'b100, SHU = 3'b101;
  typedef struct {
    logic [29:0] w;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  ent_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_err_addr = '0;
  store_align_buffer_if #(.DEPTH(DEPTH)) bus();
  store_align_buffer #(.DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  function automatic logic [31:0] mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    int n = q.size();
    chk("st_ready", 32'(bus.st_ready), 32'(n < DEPTH));
    chk("mem_valid", 32'(bus.mem_valid), 32'(n > 0));
    chk("count", 32'(bus.count), 32'(n));
    chk("err_valid", 32'(bus.err_valid), 32'(exp_err));
    chk("err_addr", bus.err_addr, exp_err_addr);
    if (n > 0) begin
      chk("mem_addr", bus.mem_addr, {q[0].w, 2'b00});
      chk("mem_be", 32'(bus.mem_be), 32'(q[0].be));
      chk("mem_data", bus.mem_data & mask(q[0].be), q[0].d & mask(q[0].be));
    end else begin
      chk("mem_addr_idle", bus.mem_addr, 32'h0);
      chk("mem_be_idle", 32'(bus.mem_be), 32'h0);
      chk("mem_data_idle", bus.mem_data, 32'h0);
    end
  endtask
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f, input logic mr);
    int          n;
    logic        take, deq, ok, merged;
    logic [3:0]  be;
    logic [31:0] nd;
    int          sh;
    ent_t        e;
    bus.st_valid  = v;
    bus.st_addr   = a;
    bus.st_data   = d;
    bus.st_func   = f;
    bus.mem_ready = mr;
    #1;
    check_all();
    @(posedge clock);
    n      = q.size();
    take   = v && n < DEPTH;
    deq    = n > 0 && mr;
    sh     = 8 * int'(a[1:0]);
    ok     = 1'b0;
    be     = '0;
    nd     = '0;
    merged = 1'b0;
    if (f == SB || f == SBU) begin
      ok = 1'b1; be = 4'b0001 << a[1:0]; nd = {24'h0, d[7:0]} << sh;
    end else if ((f == SH || f == SHU) && !a[0]) begin
      ok = 1'b1; be = 4'b0011 << a[1:0]; nd = {16'h0, d[15:0]} << sh;
    end else if (f == SW && a[1:0] == 2'b00) begin
      ok = 1'b1; be = 4'b1111; nd = d;
    end
    exp_err = take && !ok;
    if (exp_err) exp_err_addr = a;
`ifdef STORE_MERGE_EN
    if (take && ok && n >= 2 && q[n-1].w == a[31:2]) begin
      e = q[n-1];
      e.d = (e.d & ~mask(be)) | nd;
      e.be = e.be | be;
      q[n-1] = e;
      merged = 1'b1;
    end
`endif
    if (deq) void'(q.pop_front());
    if (take && ok && !merged) begin
      e.w = a[31:2]; e.d = nd; e.be = be;
      q.push_back(e);
    end
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    exp_err = 1'b0;
    exp_err_addr = '0;
  endtask
  initial begin
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_func = SB; bus.mem_ready = 1'b0;
    do_reset();
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
    chk("rst_st_ready", 32'(bus.st_ready), 32'h1);
    step(1, 32'h1000, 32'hDEADBEEF, SW, 1);
    chk("sw_valid", 32'(bus.mem_valid), 32'h1);
    chk("sw_addr", bus.mem_addr, 32'h1000);
    chk("sw_be", 32'(bus.mem_be), 32'hF);
    chk("sw_data", bus.mem_data, 32'hDEADBEEF);
    chk("sw_count1", 32'(bus.count), 32'h1);
    step(0, 0, 0, SB, 1);
    chk("sw_count0", 32'(bus.count), 32'h0);
    step(1, 32'h2003, 32'h000000A5, SB, 1);
    chk("sb_addr", bus.mem_addr, 32'h2000);
    chk("sb_be", 32'(bus.mem_be), 32'h8);
    chk("sb_data", 32'(bus.mem_data[31:24]), 32'hA5);
    step(0, 0, 0, SB, 1);
    step(1, 32'h2002, 32'h00001234, SH, 1);
    chk("sh_be", 32'(bus.mem_be), 32'hC);
    chk("sh_data", 32'(bus.mem_data[31:16]), 32'h1234);
    step(0, 0, 0, SB, 1);
    step(1, 32'h3001, 32'h0000BEEF, SH, 1);
    chk("mis_h_err", 32'(bus.err_valid), 32'h1);
    chk("mis_h_addr", bus.err_addr, 32'h3001);
    chk("mis_h_count", 32'(bus.count), 32'h0);
    step(0, 0, 0, SB, 1);
    chk("mis_h_pulse", 32'(bus.err_valid), 32'h0);
    step(1, 32'h3002, 32'h12345678, SW, 1);
    chk("mis_w_err", 32'(bus.err_valid), 32'h1);
    chk("mis_w_addr", bus.err_addr, 32'h3002);
    step(0, 0, 0, SB, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 32'h100 + 32'(16 * i), $urandom, SW, 0);
    chk("full_ready", 32'(bus.st_ready), 32'h0);
    chk("full_count", 32'(bus.count), 32'(DEPTH));
    step(1, 32'h200, $urandom, SW, 0);
    chk("full_hold_addr", bus.mem_addr, 32'h100);
    step(1, 32'h300, $urandom, SW, 1);
    chk("full_no_pass", 32'(bus.count), 32'(DEPTH - 1));
    step(1, 32'h400, $urandom, SW, 1);
    chk("push_pop_count", 32'(bus.count), 32'(DEPTH - 1));
    repeat (DEPTH) step(0, 0, 0, SB, 1);
    step(1, 32'h500, $urandom, SW, 0);
    step(1, 32'h600, $urandom, SW, 0);
    chk("pre_rst_count", 32'(bus.count), 32'h2);
    do_reset();
    chk("mid_rst_count", 32'(bus.count), 32'h0);
    chk("mid_rst_valid", 32'(bus.mem_valid), 32'h0);
    chk("mid_rst_ready", 32'(bus.st_ready), 32'h1);
    step(0, 0, 0, SB, 0);
    step(1, 32'h4000, 32'h11, SB, 0);
    step(1, 32'h4001, 32'h22, SB, 0);
    chk("merge_head", 32'(bus.count), 32'h2);
    step(1, 32'h4002, 32'h33, SB, 0);
`ifdef STORE_MERGE_EN
    chk("merge_count", 32'(bus.count), 32'h2);
    step(0, 0, 0, SB, 1);
    chk("merge_be", 32'(bus.mem_be), 32'h6);
    chk("merge_data", 32'(bus.mem_data[23:8]), 32'h3322);
`else
    chk("nomerge_count", 32'(bus.count), 32'h3);
`endif
    repeat (DEPTH) step(0, 0, 0, SB, 1);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 3) != 0,
           32'h7000 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3)),
           $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
    repeat (DEPTH + 1) step(0, 0, 0, SB, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
